cache_tag_ctrl: RTL and testbench

CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

---
 rtl/cache_pkg.sv | 37 +++
 rtl/cache_lru_set.sv | 36 +++
 rtl/cache_tag_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg -- shared definitions for the 4-way set-associative tag controller.
//
// Holds the default geometry (tag width, set-index width, associativity),
// the controller FSM state encoding, the way-index type, the per-set LRU age
// vector type, and the helper that produces the reset age pattern.
package cache_pkg;

  localparam int TAG_W = 3;  // tag width in bits
  localparam int IDX_W = 2;  // set-index width in bits, SETS = 2**IDX_W
  localparam int WAYS  = 4;  // associativity, fixed: way index is 2 bits

  // Way index within a set.
  typedef logic [1:0] way_t;

  // One 2-bit LRU age per way; age 0 is most recently used, age 3 is the
  // replacement candidate once every way is valid.
  typedef logic [1:0] age_t;
  typedef age_t [3:0] ages_t;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Reset age pattern: age[w] = w, which is already a valid permutation.
  function automatic ages_t reset_ages();
    ages_t a;
    for (int w = 0; w < 4; w++) begin
      a[w] = w[1:0];
    end
    return a;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// cache_lru_set -- LRU age update for one 4-way set.
//
// Purely combinational. Given the current ages of a set and the way being
// accessed, returns the new ages: the accessed way becomes 0, every way that
// was younger than the accessed way ages by one, older ways keep their age.
// A permutation of 0..3 in gives a permutation of 0..3 out.
//
// Ports:
//   ages_i  current ages of the set
//   way_i   accessed way
//   ages_o  updated ages
module cache_lru_set
  import cache_pkg::*;
(
  input  ages_t ages_i,
  input  way_t  way_i,
  output ages_t ages_o
);

  age_t acc_age;

  always_comb begin
    acc_age = ages_i[way_i];
    ages_o  = ages_i;
    for (int w = 0; w < 4; w++) begin
      if (w[1:0] == way_i) begin
        ages_o[w] = 2'd0;
      end else if (ages_i[w] < acc_age) begin
        ages_o[w] = ages_i[w] + 2'd1;
      end else begin
        ages_o[w] = ages_i[w];
      end
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl -- tag lookup / fill controller for a 4-way set-associative
// cache with true-LRU replacement.
//
// A request is accepted in IDLE, its tag is compared against every way of the
// indexed set in LOOKUP, a miss waits in FILL for the next level to deliver
// the line, and RESP issues a one-cycle response strobe. Only the indexed set
// is ever modified.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    lookup request present
//   req_ready    block can accept a request (high only in IDLE)
//   req_addr     {tag, index}, tag in the MSBs
//   fill_req     miss outstanding, line fetch requested (high in FILL)
//   fill_ack     next level delivered the line (ignored outside FILL)
//   resp_valid   one-cycle response strobe
//   resp_hit     1 = hit, 0 = miss serviced by fill (0 when resp_valid=0)
//   resp_way     way holding the line (0 when resp_valid=0)
//   dbg_state    current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_addr is captured on that edge. The requester
// may hold req_valid high across cycles; the next transfer simply happens the
// next time req_ready is high. fill_req stays high until fill_ack is sampled
// high; there is no separate fill valid/ready pair.
module cache_tag_ctrl #(
  parameter int TAG_W = cache_pkg::TAG_W,
  parameter int IDX_W = cache_pkg::IDX_W,
  parameter int WAYS  = cache_pkg::WAYS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TAG_W+IDX_W-1:0] req_addr,
  output logic                   fill_req,
  input  logic                   fill_ack,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [1:0]             resp_way,
  output cache_pkg::state_e      dbg_state
);

  import cache_pkg::*;

  localparam int SETS = 1 << IDX_W;

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  way_t               victim_q, victim_d;
  way_t               way_q, way_d;
  logic               hit_q, hit_d;

  // ---------------------------------------------------------------------
  // Per-set storage
  // ---------------------------------------------------------------------
  logic [TAG_W-1:0]   tag_mem_q [SETS][WAYS];
  logic [WAYS-1:0]    valid_q   [SETS];
  ages_t              age_q     [SETS];

  // ---------------------------------------------------------------------
  // Lookup and victim selection on the indexed set
  // ---------------------------------------------------------------------
  logic [WAYS-1:0]    hit_vec;
  logic               hit_any;
  way_t               hit_way;
  logic               all_valid;
  way_t               victim_way;

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx_q][w] && (tag_mem_q[idx_q][w] == tag_q);
    end
    hit_any = |hit_vec;

    // Descending scan so the lowest-numbered matching way is the last
    // assignment; a multi-way hit cannot arise from normal fills.
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_way = w[1:0];
      end
    end

    // Victim: lowest invalid way, otherwise the way whose age is 3.
    all_valid  = &valid_q[idx_q];
    victim_way = '0;
    if (all_valid) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (age_q[idx_q][w] == 2'd3) begin
          victim_way = w[1:0];
        end
      end
    end else begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!valid_q[idx_q][w]) begin
          victim_way = w[1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // LRU update for the indexed set (single shared instance)
  // ---------------------------------------------------------------------
  logic   lru_en;
  way_t   lru_way;
  ages_t  lru_ages;

  cache_lru_set u_lru (
    .ages_i (age_q[idx_q]),
    .way_i  (lru_way),
    .ages_o (lru_ages)
  );

  // ---------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------
  logic fill_we;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    victim_d = victim_q;
    way_d    = way_q;
    hit_d    = hit_q;
    lru_en   = 1'b0;
    lru_way  = hit_way;
    fill_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tag_d   = req_addr[TAG_W+IDX_W-1 -: TAG_W];
          idx_d   = req_addr[IDX_W-1:0];
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (hit_any) begin
          hit_d   = 1'b1;
          way_d   = hit_way;
          lru_en  = 1'b1;
          lru_way = hit_way;
          state_d = ST_RESP;
        end else begin
          victim_d = victim_way;
          state_d  = ST_FILL;
        end
      end

      ST_FILL: begin
        if (fill_ack) begin
          fill_we = 1'b1;
          lru_en  = 1'b1;
          lru_way = victim_q;
          hit_d   = 1'b0;
          way_d   = victim_q;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control register update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      victim_q <= '0;
      way_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      victim_q <= victim_d;
      way_q    <= way_d;
      hit_q    <= hit_d;
    end
  end

  // Valid bits and ages: reset to empty sets with age[w] = w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= reset_ages();
      end
    end else begin
      if (fill_we) begin
        valid_q[idx_q][victim_q] <= 1'b1;
      end
      if (lru_en) begin
        age_q[idx_q] <= lru_ages;
      end
    end
  end

  // Tag storage carries no reset: a way's tag is meaningless until its valid
  // bit is set, and reset forces the FSM out of FILL so no write can occur.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem_q[idx_q][victim_q] <= tag_q;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded straight from the state so reset forces them at once.
  // ---------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);
  assign fill_req   = (state_q == ST_FILL);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_hit   = resp_valid & hit_q;
  assign resp_way   = resp_valid ? way_q : 2'b00;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
module tb_cache_tag_ctrl;
  import cache_pkg::*;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_addr = '0;
  logic       fill_ack = 1'b0;
  logic       req_ready, fill_req, resp_valid, resp_hit;
  logic [1:0] resp_way;
  state_e     dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  cache_tag_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .fill_req   (fill_req),
    .fill_ack   (fill_ack),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: tags, valid bits and LRU ages per set
  // ---------------------------------------------------------------------
  logic [2:0] m_tag   [4][4];
  logic       m_valid [4][4];
  logic [1:0] m_age   [4][4];

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_age[s][w]   = w[1:0];
      end
    end
  endtask

  // Returns {hit, way} for an access and updates the model.
  task automatic model_access(input logic [4:0] addr, output logic [2:0] e);
    logic [2:0] t;
    logic [1:0] s;
    logic [1:0] a;
    int w;
    t = addr[4:2];
    s = addr[1:0];
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
    if (w >= 0) begin
      e = {1'b1, w[1:0]};
    end else begin
      for (int i = 0; i < 4; i++)
        if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0)
        for (int i = 0; i < 4; i++)
          if (m_age[s][i] == 2'd3) w = i;
      m_valid[s][w] = 1'b1;
      m_tag[s][w]   = t;
      e = {1'b0, w[1:0]};
    end
    a = m_age[s][w];
    for (int i = 0; i < 4; i++) begin
      if (i == w) m_age[s][i] = 2'd0;
      else if (m_age[s][i] < a) m_age[s][i] = m_age[s][i] + 2'd1;
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard: expected {hit, way} per accepted request
  // ---------------------------------------------------------------------
  logic [2:0] exp_q[$];

  always @(negedge clk) begin : mon
    logic [2:0] e;
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_hit", 32'(resp_hit), 32'(e[2]));
          chk("resp_way", 32'(resp_way), 32'(e[1:0]));
        end
      end else begin
        chk("resp_zero_when_idle", 32'({resp_hit, resp_way}), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    fill_ack  = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One request; miss path waits ack_dly cycles in FILL before fill_ack.
  task automatic do_req(input logic [4:0] addr, input int ack_dly,
                        output logic got_hit, output logic [1:0] got_way);
    logic [2:0] e;
    model_access(addr, e);
    exp_q.push_back(e);
    @(negedge clk);
    chk("ready_in_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_low_lookup", 32'(req_ready), 32'd0);
    chk("no_fill_in_lookup", 32'(fill_req), 32'd0);
    @(negedge clk);
    if (!e[2]) begin
      chk("fill_req_rise", 32'(fill_req), 32'd1);
      repeat (ack_dly) begin
        @(negedge clk);
        chk("fill_hold", 32'({fill_req, resp_valid}), 32'b10);
      end
      fill_ack = 1'b1;
      @(negedge clk);
      fill_ack = 1'b0;
    end else begin
      chk("no_fill_on_hit", 32'(fill_req), 32'd0);
    end
    chk("resp_latency", 32'(resp_valid), 32'd1);
    got_hit = resp_hit;
    got_way = resp_way;
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic       h;
    logic [1:0] w;
    int         acc;
    int         acc_cyc[10];
    logic [2:0] e;

    model_reset();
    repeat (2) @(negedge clk);
    // Outputs while reset is held
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", 32'({fill_req, resp_valid, resp_hit, resp_way}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    apply_reset();

    // Cold miss then hit on 0b101_10
    do_req(5'b101_10, 3, h, w);
    chk("cold_miss_hit", 32'(h), 32'd0);
    chk("cold_miss_way", 32'(w), 32'd0);
    do_req(5'b101_10, 0, h, w);
    chk("rehit_hit", 32'(h), 32'd1);
    chk("rehit_way", 32'(w), 32'd0);

    // Fill set 2 with tags 1..4, hit tag 1, then tag 5 must evict way 1
    apply_reset();
    for (int t = 1; t <= 4; t++) begin
      logic [2:0] tt;
      tt = t[2:0];
      do_req({tt, 2'b10}, 1, h, w);
      chk("fill_set_way", 32'(w), 32'(t - 1));
    end
    do_req(5'b001_10, 0, h, w);
    chk("lru_hit_tag1", 32'({h, w}), 32'b100);
    do_req(5'b101_10, 2, h, w);
    chk("lru_victim_hit", 32'(h), 32'd0);
    chk("lru_victim_way", 32'(w), 32'd1);

    // Reset asserted mid-FILL: outputs drop at once, request is abandoned
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 5'b110_10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_fill", 32'(fill_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    chk("async_rst_outputs", 32'({fill_req, resp_valid, resp_hit, resp_way}), 32'd0);
    apply_reset();
    do_req(5'b110_10, 1, h, w);
    chk("post_rst_miss", 32'({h, w}), 32'b000);

    // fill_ack pulsed in IDLE must be ignored; cold request still waits
    @(negedge clk);
    fill_ack = 1'b1;
    @(negedge clk);
    fill_ack = 1'b0;
    chk("ack_in_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    do_req(5'b111_00, 2, h, w);
    chk("stray_ack_miss", 32'(h), 32'd0);

    // req_valid held high for 10 requests to one address
    apply_reset();
    acc = 0;
    req_addr = 5'b011_01;
    for (int t = 0; t < 100 && !(acc == 10 && exp_q.size() == 0); t++) begin
      @(negedge clk);
      req_valid = (acc < 10);
      if (req_valid && req_ready) begin
        model_access(req_addr, e);
        exp_q.push_back(e);
        acc_cyc[acc] = cyc;
        acc++;
      end
      fill_ack = fill_req && !fill_ack;
    end
    req_valid = 1'b0;
    fill_ack  = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd10);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    for (int k = 1; k < 9 && k + 1 < acc; k++) begin
      chk("stream_gap", 32'(acc_cyc[k+1] - acc_cyc[k]), 32'd3);
    end

    // Random traffic across all sets
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      do_req(a, int'($urandom_range(0, 3)), h, w);
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
